// File: rtl/pipe_pkg.sv
// Shared pipeline types: decoded control bundle, ALU opcodes and the bubble constant.
package pipe_pkg;

    localparam logic [2:0] ALUOP_SUB  = 3'b000;
    localparam logic [2:0] ALUOP_NEG  = 3'b001;
    localparam logic [2:0] ALUOP_INC  = 3'b010;
    localparam logic [2:0] ALUOP_NOP  = 3'b011;
    localparam logic [2:0] ALUOP_ADD  = 3'b100;
    localparam logic [2:0] ALUOP_PASS = 3'b111;

    typedef struct packed {
        logic       regwrt;
        logic       memrd;
        logic       memwrt;
        logic       alusrc;
        logic       memtoreg;
        logic       branch;
        logic       btype;
        logic       jump;
        logic [2:0] aluop;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        regwrt:   1'b0,
        memrd:    1'b0,
        memwrt:   1'b0,
        alusrc:   1'b0,
        memtoreg: 1'b0,
        branch:   1'b0,
        btype:    1'b0,
        jump:     1'b0,
        aluop:    ALUOP_NOP
    };

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use compare: a load sitting in EX whose destination feeds the
// instruction currently in ID. Register 0 is deliberately not treated as special.
module load_use_detect #(
    parameter int REG_IDX_W = 6
) (
    input  logic                 ex_valid,
    input  logic                 ex_memrd,
    input  logic [REG_IDX_W-1:0] ex_rd_idx,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs_idx,
    input  logic [REG_IDX_W-1:0] id_rt_idx,
    output logic                 hazard
);

    assign hazard = ex_valid & ex_memrd & id_valid &
                    ((ex_rd_idx == id_rs_idx) | (ex_rd_idx == id_rt_idx));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, hold and flush.
// Optional performance counters are built when ID_EX_PERF_CNT_EN is defined.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int PC_W      = 32,
    parameter int REG_IDX_W = 6
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_valid,
    input  logic                 in_stall,
    input  logic                 in_flush,
    input  logic                 in_ctrl_regwrt,
    input  logic                 in_ctrl_memrd,
    input  logic                 in_ctrl_memwrt,
    input  logic                 in_ctrl_alusrc,
    input  logic                 in_ctrl_memtoreg,
    input  logic                 in_ctrl_branch,
    input  logic                 in_ctrl_btype,
    input  logic                 in_ctrl_jump,
    input  logic [2:0]           in_ctrl_aluop,
    input  logic [PC_W-1:0]      in_pc,
    input  logic [DATA_W-1:0]    in_rs_data,
    input  logic [DATA_W-1:0]    in_rt_data,
    input  logic [DATA_W-1:0]    in_imm,
    input  logic [REG_IDX_W-1:0] in_rs_idx,
    input  logic [REG_IDX_W-1:0] in_rt_idx,
    input  logic [REG_IDX_W-1:0] in_rd_idx,
    output logic                 out_valid,
    output logic                 out_ctrl_regwrt,
    output logic                 out_ctrl_memrd,
    output logic                 out_ctrl_memwrt,
    output logic                 out_ctrl_alusrc,
    output logic                 out_ctrl_memtoreg,
    output logic                 out_ctrl_branch,
    output logic                 out_ctrl_btype,
    output logic                 out_ctrl_jump,
    output logic [2:0]           out_ctrl_aluop,
    output logic [PC_W-1:0]      out_pc,
    output logic [DATA_W-1:0]    out_rs_data,
    output logic [DATA_W-1:0]    out_rt_data,
    output logic [DATA_W-1:0]    out_imm,
    output logic [REG_IDX_W-1:0] out_rd_idx,
`ifdef ID_EX_PERF_CNT_EN
    output logic [31:0]          out_bubble_cnt,
    output logic [31:0]          out_hazard_cnt,
`endif
    output logic                 out_hazard_stall
);

    ctrl_t ctrl_in;
    ctrl_t ctrl_q;
    logic  hazard;

    assign ctrl_in = '{
        regwrt:   in_ctrl_regwrt,
        memrd:    in_ctrl_memrd,
        memwrt:   in_ctrl_memwrt,
        alusrc:   in_ctrl_alusrc,
        memtoreg: in_ctrl_memtoreg,
        branch:   in_ctrl_branch,
        btype:    in_ctrl_btype,
        jump:     in_ctrl_jump,
        aluop:    in_ctrl_aluop
    };

    load_use_detect #(
        .REG_IDX_W (REG_IDX_W)
    ) u_load_use_detect (
        .ex_valid  (out_valid),
        .ex_memrd  (ctrl_q.memrd),
        .ex_rd_idx (out_rd_idx),
        .id_valid  (in_valid),
        .id_rs_idx (in_rs_idx),
        .id_rt_idx (in_rt_idx),
        .hazard    (hazard)
    );

    // A flush or downstream hold overrides the stall request: upstream re-presents anyway.
    assign out_hazard_stall = hazard & ~in_stall & ~in_flush;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            out_valid   <= 1'b0;
            ctrl_q      <= CTRL_BUBBLE;
            out_pc      <= '0;
            out_rs_data <= '0;
            out_rt_data <= '0;
            out_imm     <= '0;
            out_rd_idx  <= '0;
        end else if (!in_stall) begin
            if (in_flush || hazard) begin
                out_valid   <= 1'b0;
                ctrl_q      <= CTRL_BUBBLE;
                out_pc      <= '0;
                out_rs_data <= '0;
                out_rt_data <= '0;
                out_imm     <= '0;
                out_rd_idx  <= '0;
            end else begin
                out_valid   <= in_valid;
                ctrl_q      <= in_valid ? ctrl_in : CTRL_BUBBLE;
                out_pc      <= in_pc;
                out_rs_data <= in_rs_data;
                out_rt_data <= in_rt_data;
                out_imm     <= in_imm;
                out_rd_idx  <= in_rd_idx;
            end
        end
    end

    assign out_ctrl_regwrt   = ctrl_q.regwrt;
    assign out_ctrl_memrd    = ctrl_q.memrd;
    assign out_ctrl_memwrt   = ctrl_q.memwrt;
    assign out_ctrl_alusrc   = ctrl_q.alusrc;
    assign out_ctrl_memtoreg = ctrl_q.memtoreg;
    assign out_ctrl_branch   = ctrl_q.branch;
    assign out_ctrl_btype    = ctrl_q.btype;
    assign out_ctrl_jump     = ctrl_q.jump;
    assign out_ctrl_aluop    = ctrl_q.aluop;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q;
    logic [31:0] hazard_cnt_q;

    // Hazard bubbles are counted only when the hazard, not a flush, caused the bubble.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            bubble_cnt_q <= '0;
            hazard_cnt_q <= '0;
        end else if (!in_stall) begin
            if (in_flush || hazard || !in_valid)
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            if (!in_flush && hazard)
                hazard_cnt_q <= hazard_cnt_q + 32'd1;
        end
    end

    assign out_bubble_cnt = bubble_cnt_q;
    assign out_hazard_cnt = hazard_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; counter checks build with ID_EX_PERF_CNT_EN.
module tb_id_ex_stage;
    import pipe_pkg::*;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        in_valid, in_stall, in_flush;
    logic        in_ctrl_regwrt, in_ctrl_memrd, in_ctrl_memwrt, in_ctrl_alusrc;
    logic        in_ctrl_memtoreg, in_ctrl_branch, in_ctrl_btype, in_ctrl_jump;
    logic [2:0]  in_ctrl_aluop;
    logic [31:0] in_pc, in_rs_data, in_rt_data, in_imm;
    logic [5:0]  in_rs_idx, in_rt_idx, in_rd_idx;
    logic        out_valid;
    logic        out_ctrl_regwrt, out_ctrl_memrd, out_ctrl_memwrt, out_ctrl_alusrc;
    logic        out_ctrl_memtoreg, out_ctrl_branch, out_ctrl_btype, out_ctrl_jump;
    logic [2:0]  out_ctrl_aluop;
    logic [31:0] out_pc, out_rs_data, out_rt_data, out_imm;
    logic [5:0]  out_rd_idx;
    logic        out_hazard_stall;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] out_bubble_cnt, out_hazard_cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 in_clk = ~in_clk;

    id_ex_stage dut (
        .in_clk            (in_clk),
        .in_rst            (in_rst),
        .in_valid          (in_valid),
        .in_stall          (in_stall),
        .in_flush          (in_flush),
        .in_ctrl_regwrt    (in_ctrl_regwrt),
        .in_ctrl_memrd     (in_ctrl_memrd),
        .in_ctrl_memwrt    (in_ctrl_memwrt),
        .in_ctrl_alusrc    (in_ctrl_alusrc),
        .in_ctrl_memtoreg  (in_ctrl_memtoreg),
        .in_ctrl_branch    (in_ctrl_branch),
        .in_ctrl_btype     (in_ctrl_btype),
        .in_ctrl_jump      (in_ctrl_jump),
        .in_ctrl_aluop     (in_ctrl_aluop),
        .in_pc             (in_pc),
        .in_rs_data        (in_rs_data),
        .in_rt_data        (in_rt_data),
        .in_imm            (in_imm),
        .in_rs_idx         (in_rs_idx),
        .in_rt_idx         (in_rt_idx),
        .in_rd_idx         (in_rd_idx),
        .out_valid         (out_valid),
        .out_ctrl_regwrt   (out_ctrl_regwrt),
        .out_ctrl_memrd    (out_ctrl_memrd),
        .out_ctrl_memwrt   (out_ctrl_memwrt),
        .out_ctrl_alusrc   (out_ctrl_alusrc),
        .out_ctrl_memtoreg (out_ctrl_memtoreg),
        .out_ctrl_branch   (out_ctrl_branch),
        .out_ctrl_btype    (out_ctrl_btype),
        .out_ctrl_jump     (out_ctrl_jump),
        .out_ctrl_aluop    (out_ctrl_aluop),
        .out_pc            (out_pc),
        .out_rs_data       (out_rs_data),
        .out_rt_data       (out_rt_data),
        .out_imm           (out_imm),
        .out_rd_idx        (out_rd_idx),
`ifdef ID_EX_PERF_CNT_EN
        .out_bubble_cnt    (out_bubble_cnt),
        .out_hazard_cnt    (out_hazard_cnt),
`endif
        .out_hazard_stall  (out_hazard_stall)
    );

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic present(input logic valid, input logic [31:0] pc, input logic [2:0] aluop,
                           input logic regwrt, input logic memrd, input logic jump,
                           input logic [5:0] rs, input logic [5:0] rt, input logic [5:0] rd);
        in_valid       = valid;
        in_pc          = pc;
        in_ctrl_aluop  = aluop;
        in_ctrl_regwrt = regwrt;
        in_ctrl_memrd  = memrd;
        in_ctrl_jump   = jump;
        in_rs_idx      = rs;
        in_rt_idx      = rt;
        in_rd_idx      = rd;
        in_rs_data     = pc + 32'd5;
        in_rt_data     = pc + 32'd6;
        in_imm         = pc + 32'd7;
        #1;
    endtask

    task automatic test_reset();
        in_stall = 0; in_flush = 0; in_rst = 1;
        in_ctrl_memwrt = 0; in_ctrl_alusrc = 0; in_ctrl_memtoreg = 0;
        in_ctrl_branch = 0; in_ctrl_btype = 0;
        present(1, 32'h44, ALUOP_ADD, 1, 0, 1, 6'd1, 6'd2, 6'd3);
        step(); step();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid got %b want 0", out_valid); end
        tests_run++;
        if (out_ctrl_aluop !== 3'b011) begin tests_failed++; $display("[TB] FAIL reset_aluop got %b want 011", out_ctrl_aluop); end
        tests_run++;
        if ({out_ctrl_regwrt, out_ctrl_memrd, out_ctrl_memwrt, out_ctrl_alusrc, out_ctrl_memtoreg,
             out_ctrl_branch, out_ctrl_btype, out_ctrl_jump} !== 8'h00) begin
            tests_failed++; $display("[TB] FAIL reset_ctrl got nonzero control bits want 00");
        end
        tests_run++;
        if (out_pc !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_pc got %h want 0", out_pc); end
        in_rst = 0;
    endtask

    task automatic test_normal_pass();
        present(1, 32'h10, ALUOP_ADD, 1, 0, 0, 6'd1, 6'd2, 6'd3);
        tests_run++;
        if (out_hazard_stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL pass_stall got %b want 0", out_hazard_stall); end
        step();
        tests_run++;
        if (out_pc !== 32'h10) begin tests_failed++; $display("[TB] FAIL pass_pc got %h want 10", out_pc); end
        tests_run++;
        if (out_ctrl_aluop !== 3'b100) begin tests_failed++; $display("[TB] FAIL pass_aluop got %b want 100", out_ctrl_aluop); end
        tests_run++;
        if (out_valid !== 1'b1 || out_ctrl_regwrt !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL pass_valid got valid=%b regwrt=%b want 1/1", out_valid, out_ctrl_regwrt);
        end
        tests_run++;
        if (out_rs_data !== 32'h15 || out_imm !== 32'h17 || out_rd_idx !== 6'd3) begin
            tests_failed++; $display("[TB] FAIL pass_data got rs=%h imm=%h rd=%0d want 15/17/3", out_rs_data, out_imm, out_rd_idx);
        end
    endtask

    task automatic test_load_use();
        present(1, 32'h14, ALUOP_ADD, 1, 1, 0, 6'd1, 6'd2, 6'd7);
        step();
        present(1, 32'h18, ALUOP_SUB, 1, 0, 0, 6'd7, 6'd4, 6'd8);
        tests_run++;
        if (out_hazard_stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL lu_stall got %b want 1", out_hazard_stall); end
        step();
        tests_run++;
        if (out_valid !== 1'b0 || out_ctrl_aluop !== 3'b011 || out_ctrl_regwrt !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL lu_bubble got valid=%b aluop=%b want 0/011", out_valid, out_ctrl_aluop);
        end
        tests_run++;
        if (out_hazard_stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL lu_clear got %b want 0", out_hazard_stall); end
        step();
        tests_run++;
        if (out_valid !== 1'b1 || out_pc !== 32'h18 || out_ctrl_aluop !== 3'b000) begin
            tests_failed++; $display("[TB] FAIL lu_replay got valid=%b pc=%h want 1/18", out_valid, out_pc);
        end
    endtask

    task automatic test_r0_and_back_to_back();
        present(1, 32'h50, ALUOP_ADD, 1, 1, 0, 6'd1, 6'd2, 6'd0);
        step();
        present(1, 32'h54, ALUOP_ADD, 1, 1, 0, 6'd9, 6'd0, 6'd4);
        tests_run++;
        if (out_hazard_stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL r0_stall got %b want 1", out_hazard_stall); end
        step();
        step();
        present(1, 32'h58, ALUOP_ADD, 1, 0, 0, 6'd5, 6'd6, 6'd10);
        tests_run++;
        if (out_pc !== 32'h54 || out_ctrl_memrd !== 1'b1 || out_hazard_stall !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL b2b_load got pc=%h memrd=%b stall=%b want 54/1/0", out_pc, out_ctrl_memrd, out_hazard_stall);
        end
        present(1, 32'h58, ALUOP_ADD, 1, 0, 0, 6'd4, 6'd6, 6'd10);
        tests_run++;
        if (out_hazard_stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_dep got %b want 1", out_hazard_stall); end
        step();
        step();
    endtask

    task automatic test_flush();
        present(1, 32'h30, ALUOP_PASS, 0, 0, 1, 6'd1, 6'd2, 6'd3);
        in_flush = 1;
        step();
        in_flush = 0;
        tests_run++;
        if (out_valid !== 1'b0 || out_ctrl_jump !== 1'b0 || out_ctrl_aluop !== 3'b011) begin
            tests_failed++; $display("[TB] FAIL flush got valid=%b jump=%b aluop=%b want 0/0/011", out_valid, out_ctrl_jump, out_ctrl_aluop);
        end
    endtask

    task automatic test_stall_over_flush();
        present(1, 32'h20, ALUOP_ADD, 1, 1, 0, 6'd1, 6'd2, 6'd9);
        step();
        present(1, 32'h40, ALUOP_SUB, 0, 0, 1, 6'd9, 6'd9, 6'd1);
        in_stall = 1; in_flush = 1; #1;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (out_hazard_stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL hold_stall[%0d] got %b want 0", i, out_hazard_stall); end
            step();
            tests_run++;
            if (out_pc !== 32'h20 || out_valid !== 1'b1 || out_ctrl_aluop !== 3'b100 || out_rd_idx !== 6'd9) begin
                tests_failed++; $display("[TB] FAIL hold[%0d] got pc=%h valid=%b aluop=%b want 20/1/100", i, out_pc, out_valid, out_ctrl_aluop);
            end
        end
        in_stall = 0; in_flush = 0;
    endtask

    task automatic test_idle_and_reset_mid();
        present(0, 32'h60, ALUOP_ADD, 1, 0, 0, 6'd30, 6'd31, 6'd12);
        step();
        tests_run++;
        if (out_valid !== 1'b0 || out_ctrl_aluop !== 3'b011 || out_ctrl_regwrt !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL idle got valid=%b aluop=%b want 0/011", out_valid, out_ctrl_aluop);
        end
        present(1, 32'h64, ALUOP_ADD, 1, 0, 0, 6'd30, 6'd31, 6'd12);
        step();
        in_rst = 1; in_stall = 1;
        step();
        in_rst = 0; in_stall = 0;
        tests_run++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_ctrl_aluop !== 3'b011) begin
            tests_failed++; $display("[TB] FAIL rst_mid got valid=%b pc=%h want 0/0", out_valid, out_pc);
        end
    endtask

`ifdef ID_EX_PERF_CNT_EN
    task automatic test_perf_counters();
        in_rst = 1;
        step();
        in_rst = 0;
        present(1, 32'h70, ALUOP_ADD, 1, 1, 0, 6'd1, 6'd2, 6'd7);
        step();
        present(1, 32'h74, ALUOP_ADD, 1, 0, 0, 6'd7, 6'd2, 6'd8);
        step();
        step();
        in_flush = 1;
        step(); step();
        in_flush = 0;
        present(0, 32'h78, ALUOP_ADD, 0, 0, 0, 6'd1, 6'd2, 6'd3);
        step();
        tests_run++;
        if (out_bubble_cnt !== 32'd4 || out_hazard_cnt !== 32'd1) begin
            tests_failed++; $display("[TB] FAIL perf_cnt got bubble=%0d hazard=%0d want 4/1", out_bubble_cnt, out_hazard_cnt);
        end
        force dut.bubble_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.bubble_cnt_q;
        step();
        tests_run++;
        if (out_bubble_cnt !== 32'd0) begin tests_failed++; $display("[TB] FAIL perf_wrap got %h want 0", out_bubble_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_normal_pass();
        test_load_use();
        test_r0_and_back_to_back();
        test_flush();
        test_stall_over_flush();
        test_idle_and_reset_mid();
`ifdef ID_EX_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
